// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory responder and its store buffer.
// Word addresses are carried at full width in buffer entries; only the low ADDR_W bits are ever non-zero.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int WADDR_W = 30;

   typedef struct packed {
      logic               valid;
      logic [WADDR_W-1:0] word_addr;
      logic [3:0]         byte_mask;
      logic [31:0]        data;
   } sb_entry_t;

   function automatic logic [3:0] lane_mask(input logic [2:0] func3, input logic [1:0] offset);
      logic [3:0] base;
      case (func3)
         F3_B, F3_BU: base = 4'b0001;
         F3_H, F3_HU: base = 4'b0011;
         default:     base = 4'b1111;
      endcase
      return base << offset;
   endfunction

   function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] offset);
      return data << {offset, 3'b000};
   endfunction

   function automatic logic [31:0] byte_bits(input logic [3:0] mask);
      return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   endfunction

   // Loads only size-check H/W; any non-byte, non-half store is handled as a word.
   function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] offset,
                                       input logic is_store);
      logic is_h;
      logic is_w;
      is_h = (func3 == F3_H) || (func3 == F3_HU);
      is_w = is_store ? !(func3 inside {F3_B, F3_BU, F3_H, F3_HU}) : (func3 == F3_W);
      return (is_h && offset[0]) || (is_w && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Coalescing FIFO of posted stores: CAM merge on word address, head drain, and load forwarding.
module store_buffer_fifo
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int SB_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      st_valid,
   input  logic [ADDR_W-1:0]         st_addr,
   input  logic [3:0]                st_mask,
   input  logic [31:0]               st_data,
   input  logic                      drain_ok,
   input  logic [ADDR_W-1:0]         ld_addr,
   output logic [3:0]                fwd_mask,
   output logic [31:0]               fwd_data,
   output logic                      pop,
   output sb_entry_t                 head_entry,
   output logic [$clog2(SB_DEPTH):0] count
);

   localparam int PTR_W = $clog2(SB_DEPTH);

   sb_entry_t        entries [SB_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] merge_idx;
   logic             hit;
   logic             merge;
   logic             push;

   assign pop        = (count != '0) && drain_ok;
   assign head_entry = entries[head];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      hit       = 1'b0;
      merge_idx = '0;
      fwd_mask  = '0;
      fwd_data  = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         // The head leaving this edge cannot absorb a merge; the store re-pushes instead.
         if (entries[i].valid && entries[i].word_addr == WADDR_W'(st_addr)
             && !(pop && PTR_W'(i) == head)) begin
            hit       = 1'b1;
            merge_idx = PTR_W'(i);
         end
         if (entries[i].valid && entries[i].word_addr == WADDR_W'(ld_addr)) begin
            fwd_mask = entries[i].byte_mask;
            fwd_data = entries[i].data;
         end
      end
   end

   assign merge = st_valid && hit;
   assign push  = st_valid && !hit;

   // NOTE: non-blocking updates; when full, pop and push hit the same slot and the later push wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SB_DEPTH; i++) entries[i] <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop) begin
            entries[head].valid <= 1'b0;
            head                <= head + PTR_W'(1);
         end
         if (merge) begin
            entries[merge_idx].byte_mask <= entries[merge_idx].byte_mask | st_mask;
            entries[merge_idx].data      <= (entries[merge_idx].data & ~byte_bits(st_mask))
                                          | (st_data & byte_bits(st_mask));
         end
         if (push) begin
            entries[tail] <= '{valid: 1'b1, word_addr: WADDR_W'(st_addr),
                               byte_mask: st_mask, data: st_data};
            tail          <= tail + PTR_W'(1);
         end
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target for the load/store port: single-port word array behind a coalescing store buffer,
// with zero-latency loads that overlay buffered bytes onto the array word.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int SB_DEPTH = 4
) (
   input  logic                      CLK,
   input  logic                      Reset,
   input  logic [31:0]               MEM_addr,
   input  logic [31:0]               MEM_WR_out,
   input  logic [2:0]                MEM_type,
   input  logic                      MEM_rd_en,
   input  logic                      MEM_wr_en,
   output logic [31:0]               MEM_data,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   output logic                      sb_empty,
   output logic                      err_misalign,
   output logic                      err_conflict
);

   logic [31:0]       mem_array [2**ADDR_W];
   logic [ADDR_W-1:0] word_addr;
   logic [1:0]        offset;
   logic              ld_misalign;
   logic              st_misalign;
   logic              st_valid;
   logic              pop;
   sb_entry_t         head_entry;
   logic [3:0]        fwd_mask;
   logic [31:0]       fwd_data;
   logic [31:0]       load_word;
   logic              unused_bits;

   assign word_addr   = MEM_addr[ADDR_W+1:2];
   assign offset      = MEM_addr[1:0];
   assign ld_misalign = MEM_rd_en && misaligned(MEM_type, offset, 1'b0);
   assign st_misalign = MEM_wr_en && !MEM_rd_en && misaligned(MEM_type, offset, 1'b1);
   assign st_valid    = MEM_wr_en && !MEM_rd_en && !misaligned(MEM_type, offset, 1'b1);
   assign unused_bits = ^{MEM_addr[31:ADDR_W+2], head_entry.valid,
                          head_entry.word_addr[WADDR_W-1:ADDR_W]};

   store_buffer_fifo #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) u_sb (
      .clk        (CLK),
      .rst_n      (Reset),
      .st_valid   (st_valid),
      .st_addr    (word_addr),
      .st_mask    (lane_mask(MEM_type, offset)),
      .st_data    (lane_shift(MEM_WR_out, offset)),
      .drain_ok   (!MEM_rd_en),
      .ld_addr    (word_addr),
      .fwd_mask   (fwd_mask),
      .fwd_data   (fwd_data),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (sb_count)
   );

   // NOTE: the array is SRAM and deliberately has no reset; only the buffer and flags are reset.
   always_ff @(posedge CLK) begin
      if (pop) begin
         for (int b = 0; b < 4; b++) begin
            if (head_entry.byte_mask[b])
               mem_array[head_entry.word_addr[ADDR_W-1:0]][8*b +: 8] <= head_entry.data[8*b +: 8];
         end
      end
   end

   assign load_word = (mem_array[word_addr] & ~byte_bits(fwd_mask)) | (fwd_data & byte_bits(fwd_mask));
   assign MEM_data  = (MEM_rd_en && !ld_misalign) ? (load_word >> {offset, 3'b000}) : '0;
   assign sb_empty  = (sb_count == '0);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         err_misalign <= 1'b0;
         err_conflict <= 1'b0;
      end else begin
         if (ld_misalign || st_misalign) err_misalign <= 1'b1;
         if (MEM_rd_en && MEM_wr_en)     err_conflict <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios then random traffic against an architectural memory model
// (backing words plus an ordered list of pending stores).
module tb_data_mem_responder;

   localparam int ADDR_W   = 10;
   localparam int SB_DEPTH = 4;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] MEM_addr, MEM_WR_out, MEM_data;
   logic [2:0]  MEM_type;
   logic        MEM_rd_en, MEM_wr_en;
   logic [$clog2(SB_DEPTH):0] sb_count;
   logic        sb_empty, err_misalign, err_conflict;

   data_mem_responder #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
      .CLK(CLK), .Reset(Reset), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
      .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
      .MEM_data(MEM_data), .sb_count(sb_count), .sb_empty(sb_empty),
      .err_misalign(err_misalign), .err_conflict(err_conflict)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int unsigned waddr;
      logic [3:0]  mask;
      logic [31:0] data;
   } pend_t;

   logic [31:0] ref_mem [1024];
   pend_t       pend [$];
   bit          ref_mis, ref_conf;
   int          checks, errors;
   logic [31:0] last_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] t, input bit is_store);
      if (t == 3'd0 || t == 3'd4) return 1;
      if (t == 3'd1 || t == 3'd5) return 2;
      if (is_store || t == 3'd2) return 4;
      return 1;
   endfunction

   function automatic bit is_mis(input logic [2:0] t, input logic [31:0] addr, input bit is_store);
      return (int'(addr[1:0]) % acc_size(t, is_store)) != 0;
   endfunction

   // What the CPU should see: backing word with every pending store applied in program order.
   function automatic logic [31:0] arch_word(input int unsigned w);
      logic [31:0] word = ref_mem[w];
      foreach (pend[i]) begin
         if (pend[i].waddr == w)
            for (int b = 0; b < 4; b++)
               if (pend[i].mask[b]) word[8*b +: 8] = pend[i].data[8*b +: 8];
      end
      return word;
   endfunction

   task automatic model_edge(input bit rd, input bit wr, input logic [2:0] t,
                             input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned w   = int'(addr[11:2]);
      int          off = int'(addr[1:0]);
      bit          pop = (pend.size() > 0) && !rd;
      bit          st  = wr && !rd && !is_mis(t, addr, 1'b1);
      bit          merged = 1'b0;
      logic [3:0]  m;
      logic [31:0] d;
      pend_t       e;
      if (rd && is_mis(t, addr, 1'b0)) ref_mis = 1'b1;
      if (wr && !rd && is_mis(t, addr, 1'b1)) ref_mis = 1'b1;
      if (rd && wr) ref_conf = 1'b1;
      m = 4'(((1 << acc_size(t, 1'b1)) - 1) << off);
      d = wdata << (8 * off);
      if (st) begin
         foreach (pend[i]) begin
            if (!merged && pend[i].waddr == w && !(pop && i == 0)) begin
               e = pend[i];
               for (int b = 0; b < 4; b++) if (m[b]) e.data[8*b +: 8] = d[8*b +: 8];
               e.mask   = e.mask | m;
               pend[i]  = e;
               merged   = 1'b1;
            end
         end
      end
      if (pop) begin
         e = pend.pop_front();
         for (int b = 0; b < 4; b++) if (e.mask[b]) ref_mem[e.waddr][8*b +: 8] = e.data[8*b +: 8];
      end
      if (st && !merged) pend.push_back('{waddr: w, mask: m, data: d});
   endtask

   task automatic do_cycle(input string tag, input bit rd, input bit wr, input logic [2:0] t,
                           input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] exp;
      @(negedge CLK);
      MEM_rd_en = rd; MEM_wr_en = wr; MEM_type = t; MEM_addr = addr; MEM_WR_out = wdata;
      #1;
      exp = (rd && !is_mis(t, addr, 1'b0)) ? (arch_word(int'(addr[11:2])) >> (8 * int'(addr[1:0]))) : 32'h0;
      last_data = MEM_data;
      check({tag, "_data"}, MEM_data, exp);
      @(posedge CLK);
      model_edge(rd, wr, t, addr, wdata);
      #1;
      check({tag, "_count"}, 32'(sb_count), 32'(pend.size()));
      check({tag, "_empty"}, 32'(sb_empty), 32'(pend.size() == 0));
      check({tag, "_mis"},   32'(err_misalign), 32'(ref_mis));
      check({tag, "_conf"},  32'(err_conflict), 32'(ref_conf));
   endtask

   initial begin
      logic [31:0] vals [5];
      checks = 0; errors = 0; ref_mis = 0; ref_conf = 0;
      foreach (ref_mem[i]) ref_mem[i] = 32'h0;
      MEM_rd_en = 0; MEM_wr_en = 0; MEM_type = 3'd2; MEM_addr = 0; MEM_WR_out = 0;
      Reset = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_count", 32'(sb_count), 32'd0);
      check("rst_empty", 32'(sb_empty), 32'd1);
      check("rst_flags", {30'd0, err_misalign, err_conflict}, 32'd0);
      @(negedge CLK) Reset = 1'b1;

      // Store then forwarded load, then drained load.
      do_cycle("t1_sw", 0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
      do_cycle("t1_lw", 1, 0, 3'd2, 32'h10, 32'h0);
      check("t1_fwd", last_data, 32'hDEADBEEF);
      check("t1_cnt", 32'(sb_count), 32'd1);
      do_cycle("t1_idle", 0, 0, 3'd2, 32'h0, 32'h0);
      check("t1_drained", 32'(sb_count), 32'd0);
      do_cycle("t1_lw2", 1, 0, 3'd2, 32'h10, 32'h0);
      check("t1_arr", last_data, 32'hDEADBEEF);

      // Give every word in the test region a known value.
      for (int w = 0; w < 32; w++)
         if (w != 4) do_cycle("init", 0, 1, 3'd2, 32'(w * 4), $urandom());
      do_cycle("init_idle", 0, 0, 3'd2, 32'h0, 32'h0);

      // Partial stores into one word.
      do_cycle("t2_sw", 0, 1, 3'd2, 32'h20, 32'h0);
      do_cycle("t2_lw", 1, 0, 3'd2, 32'h20, 32'h0);
      do_cycle("t2_sb", 0, 1, 3'd0, 32'h21, 32'hFFFF_FFAA);
      do_cycle("t2_lw", 1, 0, 3'd2, 32'h20, 32'h0);
      do_cycle("t2_sh", 0, 1, 3'd1, 32'h22, 32'hBEEF_1234);
      check("t2_cnt", 32'(sb_count), 32'd1);
      do_cycle("t2_lw", 1, 0, 3'd2, 32'h20, 32'h0);
      check("t2_word", last_data, 32'h1234AA00);

      // Stores to distinct words separated by loads; nothing may be lost.
      for (int i = 0; i < SB_DEPTH + 1; i++) begin
         vals[i] = $urandom();
         do_cycle("t3_sw", 0, 1, 3'd2, 32'(32'h60 + 4 * i), vals[i]);
         do_cycle("t3_lw", 1, 0, 3'd2, 32'(32'h60 + 4 * i), 32'h0);
         check("t3_fwd", last_data, vals[i]);
      end
      repeat (2) do_cycle("t3_idle", 0, 0, 3'd2, 32'h0, 32'h0);
      for (int i = 0; i < SB_DEPTH + 1; i++) begin
         do_cycle("t3_rb", 1, 0, 3'd2, 32'(32'h60 + 4 * i), 32'h0);
         check("t3_readback", last_data, vals[i]);
      end

      // Misaligned accesses.
      do_cycle("t4_lh", 1, 0, 3'd1, 32'h31, 32'h0);
      check("t4_zero", last_data, 32'h0);
      check("t4_flag", 32'(err_misalign), 32'd1);
      do_cycle("t4_sw", 0, 1, 3'd2, 32'h42, 32'h5555_5555);
      check("t4_nopush", 32'(sb_count), 32'd0);
      do_cycle("t4_lw", 1, 0, 3'd2, 32'h40, 32'h0);
      repeat (2) do_cycle("t4_hold", 0, 0, 3'd2, 32'h0, 32'h0);

      // Conflict: load wins, store dropped, no drain.
      do_cycle("t5_sw", 0, 1, 3'd2, 32'h54, 32'hCAFE_F00D);
      do_cycle("t5_rw", 1, 1, 3'd2, 32'h50, 32'h1111_1111);
      check("t5_cnt", 32'(sb_count), 32'd1);
      check("t5_flag", 32'(err_conflict), 32'd1);
      do_cycle("t5_lw", 1, 0, 3'd2, 32'h50, 32'h0);

      // Asynchronous reset with a store still buffered.
      do_cycle("t6_sw", 0, 1, 3'd2, 32'h58, 32'h0BAD_0BAD);
      @(negedge CLK);
      MEM_rd_en = 0; MEM_wr_en = 0;
      #2 Reset = 1'b0;
      #1;
      pend.delete(); ref_mis = 0; ref_conf = 0;
      check("t6_count", 32'(sb_count), 32'd0);
      check("t6_empty", 32'(sb_empty), 32'd1);
      check("t6_flags", {30'd0, err_misalign, err_conflict}, 32'd0);
      @(negedge CLK) Reset = 1'b1;
      do_cycle("t6_lost", 1, 0, 3'd2, 32'h58, 32'h0);

      // Random traffic in the region, with upper address bits that must wrap away.
      for (int n = 0; n < 600; n++) begin
         int unsigned kind = $urandom_range(99);
         int unsigned w    = $urandom_range(31);
         logic [2:0]  lt, st;
         int          off  = $urandom_range(3);
         logic [31:0] addr;
         case ($urandom_range(4))
            0: lt = 3'd0; 1: lt = 3'd1; 2: lt = 3'd2; 3: lt = 3'd4; default: lt = 3'd5;
         endcase
         st = 3'($urandom_range(2));
         if (kind >= 20 && kind < 55 && $urandom_range(9) != 0)
            off = off - (off % acc_size(st, 1'b1));
         addr = ($urandom() & 32'hFFFF_F000) | 32'(w << 2) | 32'(off);
         if (kind < 20)      do_cycle("rnd_idle", 0, 0, lt, addr, 32'h0);
         else if (kind < 55) do_cycle("rnd_st", 0, 1, st, addr, $urandom());
         else if (kind < 95) do_cycle("rnd_ld", 1, 0, lt, addr, 32'h0);
         else                do_cycle("rnd_rw", 1, 1, lt, addr, $urandom());
      end

      repeat (3) do_cycle("fin_idle", 0, 0, 3'd2, 32'h0, 32'h0);
      for (int w = 0; w < 32; w++) do_cycle("fin_rb", 1, 0, 3'd2, 32'(w * 4), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
